apb_reg_target: RTL
===================

Name: apb_reg_target

Overview:
- APB completer (target) and register bank that terminates the `apbReg` APB link driven by an initiator such as `cpu`.
- Decodes APB transfers into a bank of 32-bit registers and inserts a programmable number of wait states.
- Flags bad accesses with pslverr.
- Exposes register contents and write strobes to local hardware, and captures a live status word for readback.

Parameters:
- ADDR_W, 12, APB address width.
- DATA_W, 32, APB data width (fixed at 32; byte strobes not supported).
- NUM_REGS, 8, total register count; minimum 3.
- WAIT_STATES, 1, access-phase cycles with pready low before completion (0..15).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- apbReg, apb_if.dst modport, -, APB completer side. Members:
  - paddr, ADDR_W
  - psel, 1
  - penable, 1
  - pwrite, 1
  - pwdata, 32
  - prdata, 32 (out)
  - pready, 1 (out)
  - pslverr, 1 (out)
- status_i, input, 32, live hardware status, readable at register NUM_REGS-2.
- ctrl_o, output, 32*(NUM_REGS-2), concatenated RW registers; reg0 in the LSBs.
- wr_pulse_o, output, 1, one-cycle pulse on each committed RW write.
- wr_idx_o, output, $clog2(NUM_REGS), index of the last committed write; valid with wr_pulse_o.

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: all RW regs 0; transfer counter 0; prdata 0; pready 0; pslverr 0; wr_pulse_o 0; wr_idx_o 0; FSM to IDLE.
- Address map:
  - idx = paddr[ADDR_W-1:2].
  - Regs 0..NUM_REGS-3 are RW.
  - Reg NUM_REGS-2 is RO and returns status_i as sampled at completion.
  - Reg NUM_REGS-1 is RO: a 32-bit count of completed error-free transfers (reads and writes), wrapping 0xFFFFFFFF -> 0.
- Error conditions (pslverr=1 on the completing cycle):
  - paddr[1:0] != 0;
  - idx >= NUM_REGS;
  - write to an RO index.
- On an error:
  - no register change and no wr_pulse_o;
  - counter not incremented;
  - prdata 0.
- FSM states:
  - IDLE: waits for setup (psel=1, penable=0); on setup, latch the wait counter = WAIT_STATES and go to ACCESS.
  - ACCESS: if psel=1 and penable=1 and cnt != 0, decrement cnt.
  - ACCESS: if cnt == 0, drive pready=1 this cycle (combinational from state/cnt, gated by psel & penable), commit the transfer, then return to IDLE.
  - ACCESS: if psel drops before completion, abort to IDLE with no commit and no error.
- Latency: completion occurs WAIT_STATES+1 cycles after the setup cycle. WAIT_STATES=0 gives a zero-wait transfer (pready high in the first access cycle).
- Outputs are valid only while pready=1:
  - prdata is driven combinationally from the decode in the completing cycle and is 0 otherwise.
  - pslverr is 0 whenever pready is 0.
- Write commit: on the completing cycle, the register updates at that clk edge. wr_pulse_o=1 and wr_idx_o=idx in the following cycle.
- Back-to-back transfers: a new setup in the cycle after completion is accepted (IDLE sees setup). No idle cycle is required between transfers.
- Counter increment and a read of the counter in the same transfer: the read returns the pre-increment value.
- Reset asserted mid-transfer: immediate return to reset values. The in-flight write is not committed.
- penable=1 seen in IDLE (protocol violation): ignored; state stays IDLE and pready=0.

Test Plan:
- Reset -> pready=0, prdata=0, ctrl_o all 0, counter reads 0.
- WAIT_STATES=1, write 0xDEADBEEF to 0x004 -> pready low 1 access cycle, then high with pslverr=0. ctrl_o[63:32]=0xDEADBEEF; wr_pulse_o=1, wr_idx_o=1 the next cycle. Read 0x004 returns 0xDEADBEEF.
- Write to 0x018 (NUM_REGS=8, RO status) -> pslverr=1, no wr_pulse_o. Read 0x018 with status_i=0x0000A5A5 -> prdata=0x0000A5A5, pslverr=0.
- Access 0x002 (unaligned) and 0x020 (out of range) -> pslverr=1, prdata=0, counter unchanged.
- Three back-to-back good transfers with WAIT_STATES=0 -> each completes in 2 cycles (setup+access). A counter read at 0x01C then returns 3.
- psel dropped during a wait state of a write, and separately rst_n pulsed mid-transfer -> target register unchanged (0), FSM IDLE, pready=0.

Source files
------------

// File: rtl/apb_reg_target_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_if
// Brief    : APB link bundle; 'dst' is the completer view, 'src' the
//            initiator view.
// Revision : 1.0 - initial release
// ============================================================================
interface apb_if #(
    parameter int ADDR_W = 12
) ();
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    modport dst (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

    modport src (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_reg_target.sv
`default_nettype none
// ============================================================================
// Module   : apb_reg_target
// Brief    : APB completer with a bank of RW control registers, a live
//            status word, a transfer counter and programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module apb_reg_target #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    apb_if.dst                               apbReg,
    input  logic [DATA_W-1:0]                status_i,
    output logic [DATA_W*(NUM_REGS-2)-1:0]   ctrl_o,
    output logic                             wr_pulse_o,
    output logic [$clog2(NUM_REGS)-1:0]      wr_idx_o
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int IW     = ADDR_W - 2;
    localparam int NUM_RW = NUM_REGS - 2;
    localparam logic [IW-1:0] STATUS_IDX = IW'(NUM_REGS - 2);
    localparam logic [IW-1:0] COUNT_IDX  = IW'(NUM_REGS - 1);
    localparam logic [3:0]    WAIT_INIT  = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [31:0]         xfer_cnt_q, xfer_cnt_d;
    logic [DATA_W-1:0]   regs_q [NUM_RW];
    logic [DATA_W-1:0]   regs_d [NUM_RW];
    logic                wr_pulse_q, wr_pulse_d;
    logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;

    logic [IW-1:0]       idx;
    logic                complete;
    logic                err;
    logic [DATA_W-1:0]   rdata;

    assign idx = apbReg.paddr[ADDR_W-1:2];

    // The transfer finishes when the wait count is exhausted while the
    // initiator is still holding the access phase.
    assign complete = (state_q == ST_ACCESS) && (cnt_q == 4'd0) &&
                      apbReg.psel && apbReg.penable;

    assign err = (apbReg.paddr[1:0] != 2'b00) ||
                 (idx > COUNT_IDX) ||
                 (apbReg.pwrite && (idx >= STATUS_IDX));

    // Register the FSM, wait counter, bank, transfer counter and write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            xfer_cnt_q <= 32'd0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            xfer_cnt_q <= xfer_cnt_d;
            wr_pulse_q <= wr_pulse_d;
            wr_idx_q   <= wr_idx_d;
            for (int i = 0; i < NUM_RW; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Next-state logic: setup arms the wait counter, access counts it down,
    // a dropped psel abandons the transfer without committing anything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (apbReg.psel && !apbReg.penable) begin
                    state_d = ST_ACCESS;
                    cnt_d   = WAIT_INIT;
                end
            end
            ST_ACCESS: begin
                if (!apbReg.psel) begin
                    state_d = ST_IDLE;
                end else if (apbReg.penable) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read decode; the counter returns its value before this transfer's
    // increment because the increment only lands at the completing edge
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (idx == IW'(i)) begin
                rdata = regs_q[i];
            end
        end
        if (idx == STATUS_IDX) begin
            rdata = status_i;
        end
        if (idx == COUNT_IDX) begin
            rdata = xfer_cnt_q;
        end
    end

    // Commit good transfers: bump the counter, update the register and
    // raise the write strobe for the following cycle
    always_comb begin
        regs_d     = regs_q;
        xfer_cnt_d = xfer_cnt_q;
        wr_pulse_d = 1'b0;
        wr_idx_d   = wr_idx_q;
        if (complete && !err) begin
            xfer_cnt_d = xfer_cnt_q + 32'd1;
            if (apbReg.pwrite) begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (idx == IW'(i)) begin
                        regs_d[i] = apbReg.pwdata;
                    end
                end
                wr_pulse_d = 1'b1;
                wr_idx_d   = idx[IDX_W-1:0];
            end
        end
    end

    assign apbReg.pready  = complete;
    assign apbReg.pslverr = complete && err;
    assign apbReg.prdata  = (complete && !err && !apbReg.pwrite) ? rdata : '0;

    assign wr_pulse_o = wr_pulse_q;
    assign wr_idx_o   = wr_idx_q;

    generate
        for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
            assign ctrl_o[g*DATA_W +: DATA_W] = regs_q[g];
        end
    endgenerate

endmodule
`default_nettype wire
